// File: rtl/v_store_serializer.sv
// Serializes one captured vector register into BEAT_W-wide memory write beats with byte strobes.
// Latency: first beat valid the cycle after acceptance; one beat per cycle while mem_ready_i is high.
// Backpressure: beat outputs held stable while mem_ready_i is low; vs_ready_o only asserted when idle.
module v_store_serializer #(
    parameter int VLEN   = 512,
    parameter int BEAT_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vs_valid_i,
    output logic                  vs_ready_o,
    input  logic [VLEN-1:0]       vs_data_i,
    input  logic [31:0]           vs_addr_i,
    input  logic [6:0]            vs_nbytes_i,
    output logic                  mem_valid_o,
    input  logic                  mem_ready_i,
    output logic [31:0]           mem_addr_o,
    output logic [BEAT_W-1:0]     mem_wdata_o,
    output logic [BEAT_W/8-1:0]   mem_wstrb_o,
    output logic                  mem_last_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int         BB        = BEAT_W / 8;
    localparam int         NBEATS    = VLEN / BEAT_W;
    localparam int         CW        = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [6:0] MAX_BYTES = 7'(VLEN / 8);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [VLEN-1:0] data_q;
    logic [31:0]     addr_q;
    logic [6:0]      nbytes_q;
    logic [CW-1:0]   beat_q;
    logic            err_q;

    logic            accept;
    logic            req_bad;
    logic            beat_hs;
    logic            beat_last;
    logic [7:0]      bytes_left;

    assign accept  = vs_valid_i && vs_ready_o;
    assign req_bad = ((vs_addr_i & 32'(BB - 1)) != 32'd0)
                     || (vs_nbytes_i == 7'd0)
                     || (vs_nbytes_i > MAX_BYTES);
    assign beat_hs = mem_valid_o && mem_ready_i;

    // Bytes still owed from the current beat onward; the last beat is the one that covers the remainder.
    assign bytes_left = {1'b0, nbytes_q} - 8'(32'(beat_q) * BB);
    assign beat_last  = (bytes_left <= 8'(BB));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !req_bad) state_d = SEND;
            SEND:    if (beat_hs && beat_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vs_ready_o  = rst && (state_q == IDLE);
        mem_valid_o = (state_q == SEND);
        done_o      = (state_q == DONE);
        err_o       = err_q;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wstrb_o = '0;
        mem_last_o  = 1'b0;
        if (state_q == SEND) begin
            mem_addr_o  = addr_q + 32'(beat_q) * 32'(BB);
            mem_wdata_o = data_q[32'(beat_q) * BEAT_W +: BEAT_W];
            mem_last_o  = beat_last;
            for (int i = 0; i < BB; i++) begin
                mem_wstrb_o[i] = (8'(i) < bytes_left);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q   <= '0;
            addr_q   <= '0;
            nbytes_q <= '0;
            beat_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= accept && req_bad;
            if (accept && !req_bad) begin
                data_q   <= vs_data_i;
                addr_q   <= vs_addr_i;
                nbytes_q <= vs_nbytes_i;
                beat_q   <= '0;
            end else if (beat_hs && !beat_last) begin
                beat_q <= beat_q + CW'(1);
            end
        end
    end

endmodule
